// File: rtl/z_event_logger_pkg.sv
// Package: z_event_pkg
//   Shared defaults for the z event logger slice: timestamp width, FIFO depth,
//   hit counter width, and the default-width timestamp type.
package z_event_pkg;

    localparam int TS_W_DEF  = 16;
    localparam int DEPTH_DEF = 4;
    localparam int CNT_W_DEF = 8;

    typedef logic [TS_W_DEF-1:0] ts_t;

endpackage

// File: rtl/z_event_logger_fifo.sv
// Module: z_event_fifo
//   Synchronous FIFO with flush. Pointers carry an extra wrap bit so that
//   full and empty are told apart without a separate count register.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   flush          synchronous flush; empties the FIFO, overrides push/pop
//   push, din      write request and data; accepted when not full or popping
//   pop            read request; ignored while empty
//   dout           head entry, 0 while empty
//   level          occupancy 0..DEPTH
//   full, empty    status flags
module z_event_fifo
    import z_event_pkg::*;
#(
    parameter int W     = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // still accepted when the head is leaving.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/z_event_logger.sv
// Module: z_event_logger
//   Timestamps every cycle with z=1 using a free-running counter, buffers the
//   timestamps in a FIFO drained over valid/ready, and keeps a saturating hit
//   count plus a sticky overflow flag for dropped events.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   z              one event per cycle it is high
//   clr            sync clear of FIFO, hit_count and overflow (timestamp untouched)
//   ev_valid       FIFO head valid
//   ev_ready       consumer accepts head when ev_valid && ev_ready
//   ev_ts          timestamp at FIFO head, 0 when empty
//   hit_count      saturating event count since reset/clr
//   overflow       sticky: an event was dropped on a full FIFO
//   level          FIFO occupancy 0..DEPTH
module z_event_logger
    import z_event_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     z,
    input  logic                     clr,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [TS_W-1:0]          ev_ts,
    output logic [CNT_W-1:0]         hit_count,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    logic [TS_W-1:0] ts;
    logic            ev;
    logic            fifo_full;
    logic            fifo_empty;
    logic            drop;

    // An event coinciding with clr is neither counted nor stored.
    assign ev = z && !clr;

    // Full FIFO implies a valid head, so ev_ready alone decides whether a slot frees up.
    assign drop = ev && fifo_full && !ev_ready;

    always_ff @(posedge clk) begin
        if (reset) ts <= '0;
        else       ts <= ts + TS_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            hit_count <= '0;
        end else if (ev && (hit_count != '1)) begin
            hit_count <= hit_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
    end

    z_event_fifo #(
        .W     (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (clr),
        .push  (ev),
        .din   (ts),
        .pop   (ev_ready),
        .dout  (ev_ts),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ev_valid = !fifo_empty;

endmodule

// File: tb/tb_z_event_logger.sv
module tb_z_event_logger;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic z = 1'b0;
    logic clr = 1'b0;
    logic ev_ready = 1'b0;

    logic        ev_valid_a, ev_valid_b;
    logic [15:0] ev_ts_a;
    logic [3:0]  ev_ts_b;
    logic [7:0]  hc_a;
    logic [2:0]  hc_b;
    logic        ov_a, ov_b;
    logic [2:0]  lvl_a, lvl_b;

    always #5 clk = ~clk;

    z_event_logger #(.TS_W(16), .DEPTH(DEPTH), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .z(z), .clr(clr),
        .ev_valid(ev_valid_a), .ev_ready(ev_ready), .ev_ts(ev_ts_a),
        .hit_count(hc_a), .overflow(ov_a), .level(lvl_a)
    );

    z_event_logger #(.TS_W(4), .DEPTH(DEPTH), .CNT_W(3)) u_b (
        .clk(clk), .reset(reset), .z(z), .clr(clr),
        .ev_valid(ev_valid_b), .ev_ready(ev_ready), .ev_ts(ev_ts_b),
        .hit_count(hc_b), .overflow(ov_b), .level(lvl_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: absolute cycle numbers in a queue; each DUT sees them modulo its width.
    int unsigned m_cyc;
    int unsigned m_q[$];
    int unsigned m_cnt;
    bit          m_ov;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit zz, input bit cc, input bit rr);
        if (r) begin
            m_cyc = 0;
            m_q.delete();
            m_cnt = 0;
            m_ov  = 0;
        end else begin
            if (cc) begin
                m_q.delete();
                m_cnt = 0;
                m_ov  = 0;
            end else begin
                if (rr && m_q.size() > 0) m_q.delete(0);
                if (zz) begin
                    m_cnt++;
                    if (m_q.size() < DEPTH) m_q.push_back(m_cyc);
                    else                    m_ov = 1;
                end
            end
            m_cyc++;
        end
    endtask

    task automatic compare_model();
        int unsigned n;
        n = m_q.size();
        chk("valid_a", 32'(ev_valid_a), 32'(n != 0));
        chk("ts_a",    32'(ev_ts_a),    (n != 0) ? (m_q[0] & 32'hFFFF) : 32'd0);
        chk("level_a", 32'(lvl_a),      n);
        chk("count_a", 32'(hc_a),       (m_cnt > 255) ? 32'd255 : m_cnt);
        chk("ovf_a",   32'(ov_a),       32'(m_ov));
        chk("valid_b", 32'(ev_valid_b), 32'(n != 0));
        chk("ts_b",    32'(ev_ts_b),    (n != 0) ? (m_q[0] & 32'hF) : 32'd0);
        chk("level_b", 32'(lvl_b),      n);
        chk("count_b", 32'(hc_b),       (m_cnt > 7) ? 32'd7 : m_cnt);
        chk("ovf_b",   32'(ov_b),       32'(m_ov));
    endtask

    task automatic tick(input bit r, input bit zz, input bit cc, input bit rr);
        reset = r; z = zz; clr = cc; ev_ready = rr;
        @(posedge clk);
        model_step(r, zz, cc, rr);
        #1;
        compare_model();
    endtask

    typedef struct {
        bit z; bit clr; bit rdy;
        bit v; int ts; int lvl; int cnt; bit ov;
    } vec_t;

    vec_t tbl[37];
    int   drained;

    initial begin
        // Row k is applied during the cycle where ts == k; expectations are
        // the outputs seen in the following cycle on the TS_W=16 instance.
        //          z  clr rdy  v  ts  lvl cnt ov
        tbl[0]  = '{0, 0, 0,   0,  0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0,   0,  0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0,   0,  0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0,   0,  0, 0, 0, 0};
        tbl[4]  = '{0, 0, 0,   0,  0, 0, 0, 0};
        tbl[5]  = '{1, 0, 0,   1,  5, 1, 1, 0};
        tbl[6]  = '{0, 0, 1,   0,  0, 0, 1, 0};
        tbl[7]  = '{0, 1, 0,   0,  0, 0, 0, 0};
        tbl[8]  = '{0, 0, 0,   0,  0, 0, 0, 0};
        tbl[9]  = '{0, 0, 0,   0,  0, 0, 0, 0};
        tbl[10] = '{1, 0, 0,   1, 10, 1, 1, 0};
        tbl[11] = '{0, 0, 0,   1, 10, 1, 1, 0};
        tbl[12] = '{1, 0, 0,   1, 10, 2, 2, 0};
        tbl[13] = '{0, 0, 0,   1, 10, 2, 2, 0};
        tbl[14] = '{1, 0, 0,   1, 10, 3, 3, 0};
        tbl[15] = '{0, 0, 0,   1, 10, 3, 3, 0};
        tbl[16] = '{1, 0, 0,   1, 10, 4, 4, 0};
        tbl[17] = '{0, 0, 0,   1, 10, 4, 4, 0};
        tbl[18] = '{1, 0, 0,   1, 10, 4, 5, 1};
        tbl[19] = '{0, 0, 1,   1, 12, 3, 5, 1};
        tbl[20] = '{0, 0, 1,   1, 14, 2, 5, 1};
        tbl[21] = '{0, 0, 1,   1, 16, 1, 5, 1};
        tbl[22] = '{0, 0, 1,   0,  0, 0, 5, 1};
        tbl[23] = '{0, 1, 0,   0,  0, 0, 0, 0};
        tbl[24] = '{1, 0, 0,   1, 24, 1, 1, 0};
        tbl[25] = '{1, 0, 0,   1, 24, 2, 2, 0};
        tbl[26] = '{1, 0, 0,   1, 24, 3, 3, 0};
        tbl[27] = '{1, 0, 0,   1, 24, 4, 4, 0};
        tbl[28] = '{1, 0, 1,   1, 25, 4, 5, 0};
        tbl[29] = '{0, 0, 1,   1, 26, 3, 5, 0};
        tbl[30] = '{0, 0, 1,   1, 27, 2, 5, 0};
        tbl[31] = '{0, 0, 1,   1, 28, 1, 5, 0};
        tbl[32] = '{0, 0, 1,   0,  0, 0, 5, 0};
        tbl[33] = '{1, 0, 0,   1, 33, 1, 6, 0};
        tbl[34] = '{1, 0, 0,   1, 33, 2, 7, 0};
        tbl[35] = '{1, 0, 0,   1, 33, 3, 8, 0};
        tbl[36] = '{1, 1, 1,   0,  0, 0, 0, 0};

        for (int i = 0; i < 3; i++) tick(1, 0, 0, 0);
        chk("reset_valid", 32'(ev_valid_a), 32'd0);
        chk("reset_level", 32'(lvl_a), 32'd0);

        for (int i = 0; i < 37; i++) begin
            tick(0, tbl[i].z, tbl[i].clr, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), 32'(ev_valid_a), 32'(tbl[i].v));
            chk($sformatf("tbl%0d_ts", i),    32'(ev_ts_a),    tbl[i].ts);
            chk($sformatf("tbl%0d_level", i), 32'(lvl_a),      tbl[i].lvl);
            chk($sformatf("tbl%0d_count", i), 32'(hc_a),       tbl[i].cnt);
            chk($sformatf("tbl%0d_ovf", i),   32'(ov_a),       32'(tbl[i].ov));
        end

        // Timestamp wrap on the 4-bit instance: events at ts 14 and ts 1.
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 0);
        for (int i = 0; i < 14; i++) tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        chk("wrap_head0", 32'(ev_ts_b), 32'd14);
        chk("wrap_level", 32'(lvl_b), 32'd2);
        tick(0, 0, 0, 1);
        chk("wrap_head1", 32'(ev_ts_b), 32'd1);
        chk("wrap_head1_wide", 32'(ev_ts_a), 32'd17);
        tick(0, 0, 0, 1);
        chk("wrap_empty", 32'(ev_valid_b), 32'd0);

        // Nine back-to-back events with the consumer always ready.
        tick(0, 0, 1, 0);
        drained = 0;
        for (int i = 0; i < 10; i++) begin
            if (ev_valid_b) drained++;
            tick(0, (i < 9), 0, 1);
        end
        chk("sat_count_b", 32'(hc_b), 32'd7);
        chk("sat_count_a", 32'(hc_a), 32'd9);
        chk("sat_ovf", 32'(ov_b), 32'd0);
        chk("sat_drained", 32'(drained), 32'd9);
        chk("sat_level", 32'(lvl_b), 32'd0);

        // Randomized traffic, including clears and resets mid-drain.
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(99) == 0), ($urandom_range(1) == 1),
                 ($urandom_range(39) == 0), ($urandom_range(9) < 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
